// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - addressing-mode encodings, fetch FSM states and operand-count helper (HALT exists only with FETCH_ILLEGAL_TRAP_EN)
package fetch_unit_pkg;

  // Addressing mode lives in opcode[4:2]
  localparam logic [2:0] AM3_ZPG   = 3'b001;
  localparam logic [2:0] AM3_IMM   = 3'b010;
  localparam logic [2:0] AM3_ABS   = 3'b011;
  localparam logic [2:0] AM3_ZPG_X = 3'b101;
  localparam logic [2:0] AM3_ABS_Y = 3'b110;
  localparam logic [2:0] AM3_ABS_X = 3'b111;

  typedef enum logic [2:0] {
    FETCH_OP = 3'd0,
    FETCH_LO = 3'd1,
    FETCH_HI = 3'd2,
`ifdef FETCH_ILLEGAL_TRAP_EN
    ISSUE    = 3'd3,
    HALT     = 3'd4
`else
    ISSUE    = 3'd3
`endif
  } fetch_state_e;

  // Number of operand bytes that follow an opcode with the given mode
  function automatic logic [1:0] operand_count(input logic [2:0] mode);
    case (mode)
      AM3_IMM, AM3_ZPG, AM3_ZPG_X:   operand_count = 2'd1;
      AM3_ABS, AM3_ABS_X, AM3_ABS_Y: operand_count = 2'd2;
      default:                       operand_count = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_ea_calc.sv
// rtl/fetch_ea_calc.sv - combinational effective-address adder for the fetch unit
module fetch_ea_calc
  import fetch_unit_pkg::*;
#(
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic [2:0]            mode,
  input  logic [REG_WIDTH-1:0]  lo,
  input  logic [REG_WIDTH-1:0]  hi,
  input  logic [REG_WIDTH-1:0]  x_reg,
  input  logic [REG_WIDTH-1:0]  y_reg,
  input  logic [ADDR_WIDTH-1:0] operand_pc,
  output logic [ADDR_WIDTH-1:0] ea
);

  logic [REG_WIDTH-1:0]  zpx_lo;
  logic [ADDR_WIDTH-1:0] abs_base;

  // Zero-page indexing wraps inside page 0; absolute indexing carries into the high byte
  always_comb begin
    zpx_lo   = lo + x_reg;
    abs_base = ADDR_WIDTH'({hi, lo});
    ea       = '0;
    case (mode)
      AM3_IMM:   ea = operand_pc;
      AM3_ZPG:   ea = ADDR_WIDTH'(lo);
      AM3_ZPG_X: ea = ADDR_WIDTH'(zpx_lo);
      AM3_ABS:   ea = abs_base;
      AM3_ABS_X: ea = abs_base + ADDR_WIDTH'(x_reg);
      AM3_ABS_Y: ea = abs_base + ADDR_WIDTH'(y_reg);
      default:   ea = '0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - opcode/operand fetch FSM issuing decoded instructions; FETCH_ILLEGAL_TRAP_EN enables the illegal-opcode trap
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                    REG_WIDTH  = 8,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 16'h0000
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_valid,
  input  logic [REG_WIDTH-1:0]  mem_rdata,
  input  logic [REG_WIDTH-1:0]  x_reg,
  input  logic [REG_WIDTH-1:0]  y_reg,
  output logic [REG_WIDTH-1:0]  instruction,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  instruction_ready,
  input  logic                  instruction_done,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  illegal
);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [REG_WIDTH-1:0]  instruction_q, instruction_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [REG_WIDTH-1:0]  lo_q, lo_d;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] ea;
  logic [REG_WIDTH-1:0]  ea_lo;
  logic                  fetch_req;

  assign pc_inc = pc_q + ADDR_WIDTH'(1);
  // In FETCH_LO the low byte is still on the bus; in FETCH_HI it was latched earlier
  assign ea_lo  = (state_q == FETCH_HI) ? lo_q : mem_rdata;

  fetch_ea_calc #(
    .REG_WIDTH (REG_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ea_calc (
    .mode      (instruction_q[4:2]),
    .lo        (ea_lo),
    .hi        (mem_rdata),
    .x_reg     (x_reg),
    .y_reg     (y_reg),
    .operand_pc(pc_q),
    .ea        (ea)
  );

`ifdef FETCH_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
`endif

  // Next-state, datapath updates and Moore outputs of the fetch FSM
  always_comb begin
    state_d           = state_q;
    pc_d              = pc_q;
    instruction_d     = instruction_q;
    addr_d            = addr_q;
    lo_d              = lo_q;
    fetch_req         = 1'b0;
    instruction_ready = 1'b0;
`ifdef FETCH_ILLEGAL_TRAP_EN
    illegal_d         = illegal_q;
`endif
    case (state_q)
      FETCH_OP: begin
        fetch_req = 1'b1;
        if (mem_valid) begin
          instruction_d = mem_rdata;
          pc_d          = pc_inc;
          if (operand_count(mem_rdata[4:2]) == 2'd0) begin
            addr_d  = '0;
            state_d = ISSUE;
          end else begin
            state_d = FETCH_LO;
          end
`ifdef FETCH_ILLEGAL_TRAP_EN
          if (mem_rdata[1:0] == 2'b11) begin
            illegal_d = 1'b1;
            addr_d    = '0;
            state_d   = HALT;
          end
`endif
        end
      end
      FETCH_LO: begin
        fetch_req = 1'b1;
        if (mem_valid) begin
          lo_d = mem_rdata;
          pc_d = pc_inc;
          if (operand_count(instruction_q[4:2]) == 2'd1) begin
            addr_d  = ea;
            state_d = ISSUE;
          end else begin
            state_d = FETCH_HI;
          end
        end
      end
      FETCH_HI: begin
        fetch_req = 1'b1;
        if (mem_valid) begin
          pc_d    = pc_inc;
          addr_d  = ea;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        instruction_ready = 1'b1;
        if (instruction_done) begin
          state_d = FETCH_OP;
        end
      end
`ifdef FETCH_ILLEGAL_TRAP_EN
      HALT: begin
        state_d = HALT;
      end
`endif
      default: begin
        state_d = FETCH_OP;
      end
    endcase
  end

  // State and datapath registers; reset abandons any read in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FETCH_OP;
      pc_q          <= RESET_PC;
      instruction_q <= '0;
      addr_q        <= '0;
      lo_q          <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instruction_q <= instruction_d;
      addr_q        <= addr_d;
      lo_q          <= lo_d;
    end
  end

`ifdef FETCH_ILLEGAL_TRAP_EN
  // Sticky trap flag, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // Read request is masked while reset is held so the bus is quiet immediately
  assign mem_re      = fetch_req & ~reset;
  assign mem_addr    = pc_q;
  assign instruction = instruction_q;
  assign addr        = addr_q;
  assign pc          = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit (handles FETCH_ILLEGAL_TRAP_EN either way)
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_re;
  logic [15:0] mem_addr;
  logic        mem_valid;
  logic [7:0]  mem_rdata;
  logic [7:0]  x_reg;
  logic [7:0]  y_reg;
  logic [7:0]  instruction;
  logic [15:0] addr;
  logic        instruction_ready;
  logic        instruction_done;
  logic [15:0] pc;
  logic        illegal;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .REG_WIDTH (8),
    .ADDR_WIDTH(16),
    .RESET_PC  (16'h0200)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .mem_re           (mem_re),
    .mem_addr         (mem_addr),
    .mem_valid        (mem_valid),
    .mem_rdata        (mem_rdata),
    .x_reg            (x_reg),
    .y_reg            (y_reg),
    .instruction      (instruction),
    .addr             (addr),
    .instruction_ready(instruction_ready),
    .instruction_done (instruction_done),
    .pc               (pc),
    .illegal          (illegal)
  );

  // Memory with a programmable number of wait cycles per read
  logic [7:0] mem [0:65535];
  int wait_cycles;
  int wcnt = 0;

  assign mem_valid = mem_re && (wcnt >= wait_cycles);
  assign mem_rdata = mem_valid ? mem[mem_addr] : 8'h5A;

  always @(posedge clk) begin
    if (reset || !mem_re || mem_valid) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  // Accepted read addresses and request-stability monitor
  logic [15:0] acc_q[$];
  logic        pend_q = 1'b0;
  logic [15:0] pend_addr_q = 16'h0000;
  int          stable_err = 0;

  always @(posedge clk) begin
    if (!reset && mem_re && mem_valid) acc_q.push_back(mem_addr);
    pend_q      <= !reset && mem_re && !mem_valid;
    pend_addr_q <= mem_addr;
  end

  always @(negedge clk) begin
    if (!reset && pend_q && !(mem_re && mem_addr == pend_addr_q)) stable_err++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_one(input string tag, input logic [7:0] e_ins, input logic [15:0] e_addr,
                         input logic [15:0] e_pc, input int hold);
    int k;
    k = 0;
    while (!instruction_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_ready"}, {31'd0, instruction_ready}, 32'd1);
    check({tag, "_instr"}, {24'd0, instruction}, {24'd0, e_ins});
    check({tag, "_addr"}, {16'd0, addr}, {16'd0, e_addr});
    check({tag, "_pc"}, {16'd0, pc}, {16'd0, e_pc});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold"}, {7'd0, instruction_ready, instruction, addr}, {7'd0, 1'b1, e_ins, e_addr});
    end
    instruction_done = 1'b1;
    @(negedge clk);
    instruction_done = 1'b0;
    check({tag, "_drop"}, {31'd0, instruction_ready}, 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [15:0] fpc;

    reset = 1'b1;
    instruction_done = 1'b0;
    x_reg = 8'h00;
    y_reg = 8'h00;
    wait_cycles = 0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'h0200] = 8'hA9; mem[16'h0201] = 8'h42;
    mem[16'h0300] = 8'hAD; mem[16'h0301] = 8'h34; mem[16'h0302] = 8'h12;
    mem[16'h0303] = 8'hBD; mem[16'h0304] = 8'hFF; mem[16'h0305] = 8'h12;
    mem[16'h0306] = 8'hB5; mem[16'h0307] = 8'hFF;
    mem[16'h0308] = 8'hB9; mem[16'h0309] = 8'hF0; mem[16'h030A] = 8'h12;
    mem[16'h030B] = 8'hA5; mem[16'h030C] = 8'h80;
    mem[16'h030D] = 8'h03;
    mem[16'h030E] = 8'hAD; mem[16'h030F] = 8'h34; mem[16'h0310] = 8'h12;
    mem[16'h0311] = 8'hB5; mem[16'h0312] = 8'hFF;
    mem[16'h0313] = 8'hAD; mem[16'h0314] = 8'h78; mem[16'h0315] = 8'h56;

    repeat (3) @(negedge clk);
    check("rst_mem_re", {31'd0, mem_re}, 32'd0);
    check("rst_pc", {16'd0, pc}, 32'h0200);
    check("rst_instr", {24'd0, instruction}, 32'd0);
    check("rst_addr", {16'd0, addr}, 32'd0);
    check("rst_ready", {31'd0, instruction_ready}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);

    reset = 1'b0;
    #1;
    check("first_re", {31'd0, mem_re}, 32'd1);
    check("first_addr", {16'd0, mem_addr}, 32'h0200);

    run_one("lda_imm", 8'hA9, 16'h0201, 16'h0202, 0);
    check("lda_acc_n", acc_q.size(), 32'd2);
    if (acc_q.size() == 2) begin
      check("lda_acc0", {16'd0, acc_q[0]}, 32'h0200);
      check("lda_acc1", {16'd0, acc_q[1]}, 32'h0201);
    end

    // Opcode 00 is a 0-operand instruction: walk the PC up to 0300
    for (int i = 0; i < 254; i++) begin
      fpc = 16'(16'h0203 + i);
      run_one("fill", 8'h00, 16'h0000, fpc, 0);
    end

    run_one("lda_abs", 8'hAD, 16'h1234, 16'h0303, 2);
    check("abs_next_re", {31'd0, mem_re}, 32'd1);
    check("abs_next_addr", {16'd0, mem_addr}, 32'h0303);

    x_reg = 8'h01;
    run_one("abs_x", 8'hBD, 16'h1300, 16'h0306, 0);
    x_reg = 8'h02;
    run_one("zpg_x", 8'hB5, 16'h0001, 16'h0308, 0);
    y_reg = 8'h20;
    run_one("abs_y", 8'hB9, 16'h1310, 16'h030B, 0);
    run_one("zpg", 8'hA5, 16'h0080, 16'h030D, 0);

    check("op03_addr", {16'd0, mem_addr}, 32'h030D);
    @(negedge clk);
`ifdef FETCH_ILLEGAL_TRAP_EN
    check("trap_illegal", {31'd0, illegal}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("trap_hold", {29'd0, illegal, mem_re, instruction_ready}, 32'b100);
    end
`else
    check("op03_latency", {31'd0, instruction_ready}, 32'd1);
    run_one("op03", 8'h03, 16'h0000, 16'h030E, 0);
    check("op03_illegal", {31'd0, illegal}, 32'd0);

    // Three wait cycles per byte; a stray done while not ready must be ignored
    wait_cycles = 3;
    acc_q.delete();
    k = 0;
    while (!(mem_re && mem_addr == 16'h030F) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("wait_reach_lo", {16'd0, mem_addr}, 32'h030F);
    instruction_done = 1'b1;
    @(negedge clk);
    instruction_done = 1'b0;
    check("stray_done_ready", {31'd0, instruction_ready}, 32'd0);
    run_one("wait_abs", 8'hAD, 16'h1234, 16'h0311, 1);
    check("wait_acc_n", acc_q.size(), 32'd3);
    if (acc_q.size() == 3) begin
      check("wait_acc0", {16'd0, acc_q[0]}, 32'h030E);
      check("wait_acc2", {16'd0, acc_q[2]}, 32'h0310);
    end
    run_one("wait_zpgx", 8'hB5, 16'h0001, 16'h0313, 0);
    check("wait_stable", stable_err, 32'd0);

    // Reset while the high operand byte is being requested
    wait_cycles = 0;
    k = 0;
    while (!(mem_re && mem_addr == 16'h0315) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("mid_reach_hi", {16'd0, mem_addr}, 32'h0315);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_re", {31'd0, mem_re}, 32'd0);
    check("mid_rst_pc", {16'd0, pc}, 32'h0200);
    check("mid_rst_instr", {24'd0, instruction}, 32'd0);
    check("mid_rst_addr", {16'd0, addr}, 32'd0);
    check("mid_rst_ready", {31'd0, instruction_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    acc_q.delete();
    #1;
    check("refetch_re", {31'd0, mem_re}, 32'd1);
    check("refetch_addr", {16'd0, mem_addr}, 32'h0200);
    run_one("refetch", 8'hA9, 16'h0201, 16'h0202, 0);
    check("refetch_acc_n", acc_q.size(), 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter REG_WIDTH, default 8: data and index register width.
REQ-002 Parameter ADDR_WIDTH, default 16: address and PC width.
REQ-003 Parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-004 Port clk  in  1: single clock; all state updates on rising edge.
REQ-005 Port reset  in  1: asynchronous, active-high reset.
REQ-006 Port mem_re  out  1: memory read request.
REQ-007 Port mem_addr  out  ADDR_WIDTH: read address, valid while mem_re=1.
REQ-008 Port mem_valid  in  1: read data valid.
REQ-009 Port mem_rdata  in  REG_WIDTH: read data, sampled when mem_valid=1.
REQ-010 Port x_reg  in  REG_WIDTH: X index value.
REQ-011 Port y_reg  in  REG_WIDTH: Y index value.
REQ-012 Port instruction  out  REG_WIDTH: fetched opcode to decoder.
REQ-013 Port addr  out  ADDR_WIDTH: effective operand address to decoder.
REQ-014 Port instruction_ready  out  1: instruction and addr valid.
REQ-015 Port instruction_done  in  1: decoder finished current instruction.
REQ-016 Port pc  out  ADDR_WIDTH: current program counter.
REQ-017 Port illegal  out  1: illegal-opcode trap flag (only driven non-zero when FETCH_ILLEGAL_TRAP_EN defined).

Function
REQ-018 FSM states SHALL be FETCH_OP, FETCH_LO, FETCH_HI, ISSUE, HALT; HALT is reachable only with FETCH_ILLEGAL_TRAP_EN defined.
REQ-019 Memory handshake: mem_re=1 with mem_addr=pc held stable until a cycle with mem_valid=1; mem_rdata captured that edge, pc incremented by 1 (mod 2^ADDR_WIDTH), mem_re deasserted for at least the following cycle if the next state is ISSUE.
REQ-020 mem_valid while mem_re=0 SHALL be ignored.
REQ-021 FETCH_OP: capture opcode into instruction; addressing mode = opcode[4:2].
REQ-022 Operand bytes: AM3_IMM, AM3_ZPG, AM3_ZPG_X -> 1 (FETCH_LO then ISSUE); AM3_ABS, AM3_ABS_X, AM3_ABS_Y -> 2 (FETCH_LO, FETCH_HI, ISSUE); all other modes -> 0 (direct to ISSUE).
REQ-023 addr: IMM = address of the operand byte; ZPG = {00, lo}; ZPG_X = {00, (lo+x_reg) mod 256}; ABS = {hi, lo}; ABS_X/ABS_Y = ({hi,lo}+x_reg/y_reg) mod 2^16 with page-cross carry; 0-operand modes = 0.
REQ-024 addr SHALL be computed combinationally-then-registered so it is stable the same cycle instruction_ready rises.
REQ-025 ISSUE: instruction_ready=1, instruction and addr held constant until instruction_done=1 sampled; next cycle instruction_ready=0 and state FETCH_OP.
REQ-026 instruction_done while instruction_ready=0 SHALL be ignored.
REQ-027 Minimum latency: opcode at mem_valid edge N, 0-operand instruction_ready=1 in cycle N+1; 2-operand with zero-wait memory in cycle N+3 after opcode edge plus operand fetch cycles.
REQ-028 PC wrap: pc FFFF -> 0000 on increment, no flag.

Reset
REQ-029 On reset=1 (any cycle, asynchronously): state=FETCH_OP, pc=RESET_PC, instruction=0, addr=0, instruction_ready=0, illegal=0, mem_re=0; any in-flight read abandoned.
REQ-030 First mem_re SHALL assert in the first clock cycle after reset deasserts.

Configuration
REQ-031 Macro FETCH_ILLEGAL_TRAP_EN defined: opcode with [1:0]=2'b11 sets illegal=1, enters HALT, mem_re=0, instruction_ready=0, held until reset; undefined: such opcodes treated as 0-operand, illegal tied 0, no HALT state.

Structure
REQ-032 AM3_* encodings (IMM=010, ZPG=001, ZPG_X=101, ABS=011, ABS_X=111, ABS_Y=110), state encoding and operand-count function SHALL live in the shared CPU package/defines.
REQ-033 Effective-address adder SHALL be a sub-module fetch_ea_calc (combinational).

Verification
REQ-034 Reset with RESET_PC=16'h0200, zero-wait memory, LDA #$42 (A9 42) -> mem_addr 0200,0201; instruction=A9, addr=0201, ready; pc=0202.
REQ-035 AD 34 12 at 0300 (LDA abs), done pulsed 2 cycles after ready -> addr=1234, pc=0303, next mem_addr=0303.
REQ-036 BD FF 12, x_reg=01 -> addr=1300 (page cross); B5 FF, x_reg=02 -> addr=0001 (zero-page wrap).
REQ-037 mem_valid delayed 3 cycles per byte -> mem_addr/mem_re stable throughout, identical results to zero-wait.
REQ-038 reset asserted between FETCH_LO and FETCH_HI -> outputs at reset values same cycle, refetch from RESET_PC.
REQ-039 Opcode 03 with FETCH_ILLEGAL_TRAP_EN -> illegal=1, mem_re=0 forever; without -> ready with addr=0000, pc+1.
